// File: rtl/cnt10_down.sv
// Presettable 4-digit BCD decade down-counter with borrow, zero and sticky underflow.
// Borrow of one stage feeds the enable of the next higher stage for cascading.
module cnt10_down #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  bout,
  output logic                  zero,
  output logic                  uflow
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] preset;
  logic [W-1:0] dec_val;
  logic [W-1:0] san_val;
  logic [W-1:0] wrap_val;
  logic         borrow;

  // Digit-wise decrement: a zero digit under borrow becomes 9 and keeps borrowing.
  always_comb begin
    dec_val = dout;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (dout[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dout[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    san_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      san_val[4*i +: 4] = (data[4*i +: 4] > 4'd9) ? 4'd9 : data[4*i +: 4];
    end
  end

  assign wrap_val = AUTO_RELOAD ? preset : {DIGITS{4'h9}};
  assign zero     = (dout == '0);
  assign bout     = en & ~load & zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout   <= '0;
      preset <= '0;
      uflow  <= 1'b0;
    end else if (load) begin
      dout   <= san_val;
      preset <= san_val;
      uflow  <= 1'b0;
    end else if (en) begin
      if (zero) begin
        dout  <= wrap_val;
        uflow <= 1'b1;
      end else begin
        dout  <= dec_val;
      end
    end
  end

endmodule

// File: tb/tb_cnt10_down.sv
// Bench for cnt10_down: one wrap-mode and one reload-mode instance driven in parallel
// from a vector table, with expected results queued at drive time and checked after the edge.
module tb_cnt10_down;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] dout0, dout1;
  logic        bout0, bout1, zero0, zero1, uflow0, uflow1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt10_down #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .dout(dout0), .bout(bout0), .zero(zero0), .uflow(uflow0)
  );

  cnt10_down #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .dout(dout1), .bout(bout1), .zero(zero1), .uflow(uflow1)
  );

  typedef struct {
    logic        load;
    logic        en;
    logic [15:0] data;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        uf0;
    logic        uf1;
  } vec_t;

  typedef struct {
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        uf0;
    logic        uf1;
  } exp_t;

  localparam int NV = 28;
  vec_t vecs[NV];
  exp_t sb[$];
  logic [15:0] prev0 = '0;
  logic [15:0] prev1 = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    load = v.load;
    en   = v.en;
    data = v.data;
    #1;
    check($sformatf("zero0[%0d]", idx), {15'd0, zero0}, {15'd0, prev0 == 16'h0});
    check($sformatf("zero1[%0d]", idx), {15'd0, zero1}, {15'd0, prev1 == 16'h0});
    check($sformatf("bout0[%0d]", idx), {15'd0, bout0}, {15'd0, v.en & ~v.load & (prev0 == 16'h0)});
    check($sformatf("bout1[%0d]", idx), {15'd0, bout1}, {15'd0, v.en & ~v.load & (prev1 == 16'h0)});
    sb.push_back('{exp0: v.exp0, exp1: v.exp1, uf0: v.uf0, uf1: v.uf1});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard[%0d]: queue empty, expected an entry", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("dout0[%0d]", idx), dout0, e.exp0);
      check($sformatf("dout1[%0d]", idx), dout1, e.exp1);
      check($sformatf("uflow0[%0d]", idx), {15'd0, uflow0}, {15'd0, e.uf0});
      check($sformatf("uflow1[%0d]", idx), {15'd0, uflow1}, {15'd0, e.uf1});
      prev0 = e.exp0;
      prev1 = e.exp1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'h0012, 16'h0012, 16'h0012, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0011, 16'h0011, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0010, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0009, 16'h0009, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0008, 16'h0008, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0002, 16'h0002, 16'h0002, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h9999, 16'h0002, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h9998, 16'h0001, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h9998, 16'h0001, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 16'h0003, 16'h0003, 16'h0003, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0002, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 16'h0000, 16'h9999, 16'h0003, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 16'h0000, 16'h9998, 16'h0002, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 16'h7A2F, 16'h7929, 16'h7929, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 16'h0000, 16'h7928, 16'h7928, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 16'h0000, 16'h9999, 16'h0000, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 16'h0000, 16'h9998, 16'h0000, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 16'h0000, 16'h0999, 16'h0999, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 16'hFFFF, 16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 16'h0000, 16'h9998, 16'h9998, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 16'h0500, 16'h0500, 16'h0500, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 16'h0000, 16'h0499, 16'h0499, 1'b0, 1'b0};

    // Reset held low, then quiet hold for ten cycles.
    #20;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}, 100 + i);
    end

    for (int i = 0; i < NV; i++) begin
      step(vecs[i], i);
    end

    // Asynchronous reset between edges while counting.
    @(negedge clk);
    en   = 1'b1;
    load = 1'b0;
    @(posedge clk);
    #1;
    check("dout0_pre_rst", dout0, 16'h0498);
    #2;
    rst = 1'b0;
    #1;
    check("dout0_async_rst", dout0, 16'h0000);
    check("dout1_async_rst", dout1, 16'h0000);
    check("uflow0_async_rst", {15'd0, uflow0}, 16'h0000);
    check("zero0_async_rst", {15'd0, zero0}, 16'h0001);
    check("bout0_async_rst", {15'd0, bout0}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("dout0_after_rst", dout0, 16'h9999);
    check("uflow0_after_rst", {15'd0, uflow0}, 16'h0001);
    check("dout1_after_rst", dout1, 16'h0000);
    check("uflow1_after_rst", {15'd0, uflow1}, 16'h0001);
    @(posedge clk);
    #1;
    check("dout0_resume", dout0, 16'h9998);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt10_down.md
# cnt10_down

4-digit BCD decade down-counter with parallel preset, enable and borrow output. It is the counting-down counterpart of the team's decade up-counter and uses the same CLK / RST / EN / DATA / DOUT port set. Its borrow output (BOUT) behaves like the up-counter's carry, so stages cascade in the same way. It serves as a presettable countdown timer / event down-counter in the CNT10 demo designs.

## Interface
- DIGITS, 4, number of BCD digits; data width W = 4*DIGITS.
- AUTO_RELOAD, 0, underflow behaviour:
  - 0: on underflow, wrap to all-nines (9999 for DIGITS=4).
  - 1: on underflow, reload the last preset value (PRESET register).
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  count enable; decrement by one per CLK edge while high.
- LOAD  input  1  synchronous parallel load; priority over EN.
- DATA  input  W  preset value, packed BCD; digit 0 = DATA[3:0].
- DOUT  output  W  current count, packed BCD, registered.
- BOUT  output  1  borrow, combinational: EN & ~LOAD & (DOUT == 0).
- ZERO  output  1  combinational: DOUT == 0.
- UFLOW  output  1  registered sticky underflow flag.

## Operation
- Registers:
  - DOUT: the count.
  - PRESET (W bits): last loaded, sanitized value.
  - UFLOW: sticky flag.
- RST low, asynchronously and regardless of CLK:
  - DOUT = 0, PRESET = 0, UFLOW = 0.
  - Hence ZERO = 1, and BOUT = EN (LOAD low).
- Priority per rising edge: LOAD > EN > hold.
- LOAD = 1:
  - Each DATA digit is sanitized: digit value 10..15 is loaded as 9.
  - The sanitized value goes into DOUT and PRESET.
  - UFLOW is cleared.
  - EN is ignored on that edge.
- EN = 1, LOAD = 0, DOUT != 0:
  - BCD decrement. Digit 0 decrements.
  - Any digit at 0 receiving a borrow becomes 9 and passes the borrow to the next digit.
  - No binary intermediate; every digit stays within 0..9 at all times.
- EN = 1, LOAD = 0, DOUT == 0 (underflow):
  - DOUT becomes all-nines (AUTO_RELOAD=0) or PRESET (AUTO_RELOAD=1).
  - UFLOW is set to 1.
  - BOUT is high during the cycle before this edge.
- AUTO_RELOAD=1 with PRESET == 0: reload yields 0, so DOUT stays at 0. BOUT stays high while EN=1; UFLOW is set.
- EN = 0, LOAD = 0: all registers hold.
- Cascading: the BOUT of a lower stage drives the EN of the next higher stage. The higher stage decrements on the same edge that the lower stage wraps.

## Timing
- DOUT, UFLOW: update on the CLK rising edge. The new value is visible one cycle after the enabling condition.
- Load latency 1 cycle: DATA sampled at edge N appears on DOUT after edge N.
- BOUT, ZERO: combinational from registers and inputs; valid in the same cycle, no latency.
- Reset is asserted asynchronously. Release is sampled: the first count or load takes effect on the first rising edge with RST high.
- Reset asserted mid-count: DOUT forced to 0 immediately, with no wait for CLK. PRESET is lost.
- Assumed external conditions (no internal synchronization):
  - RST deasserts at least 1 ns before a CLK edge.
  - EN, LOAD and DATA are stable around the edge.

## Test plan
- Reset and hold:
  - Stimulus: RST=0 for 20 ns, then RST=1, EN=0, LOAD=0.
  - Required: DOUT=0000, ZERO=1, BOUT=0, UFLOW=0, unchanged for 10 cycles.
- Load then count:
  - Stimulus: LOAD pulse with DATA=16'h0012, then EN=1.
  - Required: DOUT sequence 0012, 0011, 0010, 0009, 0008; decade borrow correct at the 0010→0009 step.
- Underflow, wrap mode (AUTO_RELOAD=0):
  - Stimulus: load 0002, then EN=1.
  - Required: DOUT 0002, 0001, 0000, 9999, 9998. BOUT high only in the 0000 cycle. UFLOW=1 from the 9999 cycle onward; a new LOAD clears it.
- Underflow, reload mode (AUTO_RELOAD=1):
  - Stimulus: load 0003, then EN=1.
  - Required: DOUT 0003, 0002, 0001, 0000, 0003, 0002.
- Sanitize and priority:
  - Stimulus: LOAD=1 and EN=1 together, DATA=16'h7A2F.
  - Required: DOUT=7929 after the edge, with no decrement on that edge.
- Async reset mid-count:
  - Stimulus: count from 0500, then pull RST low between CLK edges.
  - Required: DOUT=0000 before the next rising edge. Counting resumes from 9999 on the first edge after release (EN=1, AUTO_RELOAD=0).
